// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM pipeline register with bubble, flush, multi-cycle temporaries and stall counter
//
// Purpose:
//   Captures execute-stage results for the memory stage. When EX stalls while
//   MEM runs, a bubble is inserted and the multi-cycle MADD/MSUB temporaries
//   (hilo/cnt) are parked here and fed back to EX. A flush kills the slot.
//   A saturating counter records the number of cycles this stage was stalled.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset (0 = reset)
//   stall[5:0]     pipeline stall vector, bit i stops stage i
//   flush          exception flush, turns the slot into a bubble
//   perf_clr       synchronous clear of stall_cycles
//   ex_*           execute-stage payload and valid bit
//   hilo_i, cnt_i  multi-cycle temporary and step count from EX
//   mem_*          registered payload towards MEM
//   hilo_o, cnt_o  registered temporary and step count back to EX
//   stall_cycles   saturating count of cycles with stall[STAGE]=1

module ex_mem_pipe #(
    parameter int                   REG_ADDR_W = 5,
    parameter int                   DATA_W     = 32,
    parameter int                   ALUOP_W    = 8,
    parameter int                   STAGE      = 3,
    parameter int                   CNT_W      = 2,
    parameter logic [ALUOP_W-1:0]   NOP_ALUOP  = '0,
    parameter int                   PERF_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic                    flush,
    input  logic                    perf_clr,
    input  logic                    ex_valid,
    input  logic [REG_ADDR_W-1:0]   ex_wd,
    input  logic                    ex_wreg,
    input  logic [DATA_W-1:0]       ex_wdata,
    input  logic [ALUOP_W-1:0]      ex_aluop,
    input  logic [DATA_W-1:0]       ex_mem_addr,
    input  logic [DATA_W-1:0]       ex_reg2,
    input  logic                    ex_whilo,
    input  logic [DATA_W-1:0]       ex_hi,
    input  logic [DATA_W-1:0]       ex_lo,
    input  logic [2*DATA_W-1:0]     hilo_i,
    input  logic [CNT_W-1:0]        cnt_i,
    output logic                    mem_valid,
    output logic [REG_ADDR_W-1:0]   mem_wd,
    output logic                    mem_wreg,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [ALUOP_W-1:0]      mem_aluop,
    output logic [DATA_W-1:0]       mem_mem_addr,
    output logic [DATA_W-1:0]       mem_reg2,
    output logic                    mem_whilo,
    output logic [DATA_W-1:0]       mem_hi,
    output logic [DATA_W-1:0]       mem_lo,
    output logic [2*DATA_W-1:0]     hilo_o,
    output logic [CNT_W-1:0]        cnt_o,
    output logic [PERF_W-1:0]       stall_cycles
);

    // stall[STAGE+1] must exist, so STAGE is limited to 0..4.
    if (STAGE < 0 || STAGE > 4) begin : g_bad_stage
        $error("ex_mem_pipe: STAGE must be in 0..4");
    end

    localparam logic [PERF_W-1:0] PERF_MAX = '1;
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    // Flop state
    logic                   valid_q,     valid_d;
    logic [REG_ADDR_W-1:0]  wd_q,        wd_d;
    logic                   wreg_q,      wreg_d;
    logic [DATA_W-1:0]      wdata_q,     wdata_d;
    logic [ALUOP_W-1:0]     aluop_q,     aluop_d;
    logic [DATA_W-1:0]      mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]      reg2_q,      reg2_d;
    logic                   whilo_q,     whilo_d;
    logic [DATA_W-1:0]      hi_q,        hi_d;
    logic [DATA_W-1:0]      lo_q,        lo_d;
    logic [2*DATA_W-1:0]    hilo_q,      hilo_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [PERF_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic stall_here;
    logic stall_next;

    assign stall_here = stall[STAGE];
    assign stall_next = stall[STAGE+1];

    // Payload / temporary update, first matching case wins.
    always_comb begin
        valid_d    = valid_q;
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        aluop_d    = aluop_q;
        mem_addr_d = mem_addr_q;
        reg2_d     = reg2_q;
        whilo_d    = whilo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        hilo_d     = hilo_q;
        cnt_d      = cnt_q;

        if (flush || (stall_here && !stall_next)) begin
            // Bubble into MEM. On a plain stall the EX temporary is parked
            // here so the multi-cycle op can resume; a flush discards it.
            valid_d    = 1'b0;
            wd_d       = '0;
            wreg_d     = 1'b0;
            wdata_d    = '0;
            aluop_d    = NOP_ALUOP;
            mem_addr_d = '0;
            reg2_d     = '0;
            whilo_d    = 1'b0;
            hi_d       = '0;
            lo_d       = '0;
            if (flush) begin
                hilo_d = '0;
                cnt_d  = '0;
            end else begin
                hilo_d = hilo_i;
                cnt_d  = cnt_i;
            end
        end else if (!stall_here) begin
            // Normal capture; any multi-cycle op has completed.
            valid_d    = ex_valid;
            wd_d       = ex_wd;
            wreg_d     = ex_wreg;
            wdata_d    = ex_wdata;
            aluop_d    = ex_aluop;
            mem_addr_d = ex_mem_addr;
            reg2_d     = ex_reg2;
            whilo_d    = ex_whilo;
            hi_d       = ex_hi;
            lo_d       = ex_lo;
            hilo_d     = '0;
            cnt_d      = '0;
        end else begin
            // Both EX and MEM stalled: MEM keeps its slot, temporary tracks EX.
            hilo_d = hilo_i;
            cnt_d  = cnt_i;
        end
    end

    // Stall counter: clear wins over increment; flush cycles still count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
        end else if (stall_here && (stall_cnt_q != PERF_MAX)) begin
            stall_cnt_d = stall_cnt_q + PERF_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            wdata_q     <= '0;
            aluop_q     <= NOP_ALUOP;
            mem_addr_q  <= '0;
            reg2_q      <= '0;
            whilo_q     <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            hilo_q      <= '0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
            aluop_q     <= aluop_d;
            mem_addr_q  <= mem_addr_d;
            reg2_q      <= reg2_d;
            whilo_q     <= whilo_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            hilo_q      <= hilo_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_valid    = valid_q;
    assign mem_wd       = wd_q;
    assign mem_wreg     = wreg_q;
    assign mem_wdata    = wdata_q;
    assign mem_aluop    = aluop_q;
    assign mem_mem_addr = mem_addr_q;
    assign mem_reg2     = reg2_q;
    assign mem_whilo    = whilo_q;
    assign mem_hi       = hi_q;
    assign mem_lo       = lo_q;
    assign hilo_o       = hilo_q;
    assign cnt_o        = cnt_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - directed self-checking bench for ex_mem_pipe

module tb_ex_mem_pipe;

    localparam logic [7:0] NOP = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        perf_clr = 1'b0;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0;
    logic [7:0]  ex_aluop = '0;
    logic [31:0] ex_mem_addr = '0;
    logic [31:0] ex_reg2 = '0;
    logic        ex_whilo = 1'b0;
    logic [31:0] ex_hi = '0;
    logic [31:0] ex_lo = '0;
    logic [63:0] hilo_i = '0;
    logic [1:0]  cnt_i = '0;

    logic        mem_valid, mem_wreg, mem_whilo;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_mem_addr, mem_reg2, mem_hi, mem_lo;
    logic [7:0]  mem_aluop;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
    logic [15:0] stall_cycles;

    logic        s_valid, s_wreg, s_whilo;
    logic [4:0]  s_wd;
    logic [31:0] s_wdata, s_mem_addr, s_reg2, s_hi, s_lo;
    logic [7:0]  s_aluop;
    logic [63:0] s_hilo;
    logic [1:0]  s_cnt;
    logic [7:0]  s_stall_cycles;

    int          pass_cnt = 0;
    int          total = 0;
    logic [15:0] exp_sc = '0;
    logic [7:0]  exp_sc_s = '0;

    always #5 clk = ~clk;

    ex_mem_pipe #(.STAGE(3), .NOP_ALUOP(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
        .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo), .hilo_o(hilo_o),
        .cnt_o(cnt_o), .stall_cycles(stall_cycles)
    );

    // Narrow counter instance so saturation is reachable in a few hundred cycles.
    ex_mem_pipe #(.STAGE(3), .NOP_ALUOP(NOP), .PERF_W(8)) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
        .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_valid(s_valid), .mem_wd(s_wd), .mem_wreg(s_wreg), .mem_wdata(s_wdata),
        .mem_aluop(s_aluop), .mem_mem_addr(s_mem_addr), .mem_reg2(s_reg2),
        .mem_whilo(s_whilo), .mem_hi(s_hi), .mem_lo(s_lo), .hilo_o(s_hilo),
        .cnt_o(s_cnt), .stall_cycles(s_stall_cycles)
    );

    // One clock edge; the counter model advances from the inputs seen at the edge.
    task automatic tick();
        if (perf_clr) begin
            exp_sc   = '0;
            exp_sc_s = '0;
        end else if (stall[3]) begin
            if (exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
            if (exp_sc_s != 8'hFF) exp_sc_s = exp_sc_s + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 6'b000000; flush = 1'b0; perf_clr = 1'b0;
        ex_valid = 1'b1; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
        ex_aluop = 8'h11; ex_mem_addr = 32'h40; ex_reg2 = 32'h99; ex_whilo = 1'b1;
        ex_hi = 32'hAA; ex_lo = 32'hBB; hilo_i = 64'h77; cnt_i = 2'd3;
        tick();
        stall = 6'b001000;
        tick();
        #3;
        rst = 1'b0;
        exp_sc = '0; exp_sc_s = '0;
        #1;
        total++;
        if ({mem_valid, mem_wd, mem_wreg, mem_wdata, mem_mem_addr, mem_reg2, mem_whilo,
             mem_hi, mem_lo, hilo_o, cnt_o, stall_cycles} !== '0)
            $display("FAIL reset_zero: outputs not all zero (wdata=%h hilo=%h sc=%h)",
                     mem_wdata, hilo_o, stall_cycles);
        else pass_cnt++;
        total++;
        if (mem_aluop !== NOP) $display("FAIL reset_aluop: got %h want %h", mem_aluop, NOP);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        stall = 6'b000000; ex_wdata = 32'hDEADBEEF;
        tick();
        total++;
        if (mem_wdata !== 32'hDEADBEEF) $display("FAIL reset_release: got %h want deadbeef", mem_wdata);
        else pass_cnt++;
    endtask

    task automatic test_capture();
        stall = 6'b000000; flush = 1'b0;
        ex_valid = 1'b1; ex_wd = 5'd5; ex_wreg = 1'b1; ex_mem_addr = 32'h100;
        ex_aluop = 8'h2C; ex_hi = 32'hC0DE; hilo_i = 64'hFFFF_0000_1111; cnt_i = 2'd2;
        tick();
        total++;
        if ({mem_wd, mem_mem_addr, mem_valid, mem_wreg} !== {5'd5, 32'h100, 1'b1, 1'b1})
            $display("FAIL capture_payload: wd=%0d addr=%h valid=%b wreg=%b want 5 100 1 1",
                     mem_wd, mem_mem_addr, mem_valid, mem_wreg);
        else pass_cnt++;
        total++;
        if ({mem_aluop, mem_hi} !== {8'h2C, 32'hC0DE})
            $display("FAIL capture_aluop_hi: aluop=%h hi=%h want 2c c0de", mem_aluop, mem_hi);
        else pass_cnt++;
        total++;
        if ({hilo_o, cnt_o} !== '0) $display("FAIL capture_temp: hilo=%h cnt=%0d want 0 0", hilo_o, cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_invalid_capture();
        stall = 6'b000000;
        ex_valid = 1'b0; ex_wdata = 32'h0BAD_F00D;
        tick();
        total++;
        if ({mem_valid, mem_wdata} !== {1'b0, 32'h0BAD_F00D})
            $display("FAIL invalid_capture: valid=%b wdata=%h want 0 0badf00d", mem_valid, mem_wdata);
        else pass_cnt++;
    endtask

    task automatic test_bubble();
        ex_valid = 1'b1;
        stall = 6'b001000; hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
        tick();
        total++;
        if ({mem_valid, mem_wreg, mem_aluop, mem_wdata} !== {1'b0, 1'b0, NOP, 32'h0})
            $display("FAIL bubble_slot: valid=%b wreg=%b aluop=%h wdata=%h want 0 0 %h 0",
                     mem_valid, mem_wreg, mem_aluop, mem_wdata, NOP);
        else pass_cnt++;
        total++;
        if ({hilo_o, cnt_o} !== {64'h1_0000_0002, 2'd1})
            $display("FAIL bubble_temp: hilo=%h cnt=%0d want 100000002 1", hilo_o, cnt_o);
        else pass_cnt++;
        total++;
        if (stall_cycles !== exp_sc) $display("FAIL bubble_count: got %0d want %0d", stall_cycles, exp_sc);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        stall = 6'b000000; ex_valid = 1'b1; ex_wdata = 32'h55;
        tick();
        stall = 6'b011000;
        for (int i = 0; i < 3; i++) begin
            ex_wdata = 32'h1000 + 32'(i);
            hilo_i = 64'hA0 + 64'(i);
            cnt_i = 2'(i);
            tick();
            total++;
            if ({mem_wdata, mem_valid} !== {32'h55, 1'b1})
                $display("FAIL hold_data[%0d]: wdata=%h valid=%b want 55 1", i, mem_wdata, mem_valid);
            else pass_cnt++;
            total++;
            if ({hilo_o, cnt_o} !== {64'hA0 + 64'(i), 2'(i)})
                $display("FAIL hold_temp[%0d]: hilo=%h cnt=%0d", i, hilo_o, cnt_o);
            else pass_cnt++;
        end
        total++;
        if (stall_cycles !== exp_sc) $display("FAIL hold_count: got %0d want %0d", stall_cycles, exp_sc);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        stall = 6'b000000; ex_valid = 1'b1;
        tick();
        flush = 1'b1; stall = 6'b001000; hilo_i = 64'h3333; cnt_i = 2'd3;
        tick();
        total++;
        if ({mem_valid, hilo_o, cnt_o, mem_aluop} !== {1'b0, 64'h0, 2'd0, NOP})
            $display("FAIL flush_bubble: valid=%b hilo=%h cnt=%0d aluop=%h", mem_valid, hilo_o, cnt_o, mem_aluop);
        else pass_cnt++;
        total++;
        if (stall_cycles !== exp_sc) $display("FAIL flush_count: got %0d want %0d", stall_cycles, exp_sc);
        else pass_cnt++;
        stall = 6'b011000;
        tick();
        total++;
        if ({mem_valid, hilo_o} !== {1'b0, 64'h0})
            $display("FAIL flush_over_hold: valid=%b hilo=%h want 0 0", mem_valid, hilo_o);
        else pass_cnt++;
        flush = 1'b0;
    endtask

    task automatic test_saturation_clear();
        stall = 6'b001000;
        for (int i = 0; i < 260; i++) tick();
        total++;
        if (s_stall_cycles !== 8'hFF) $display("FAIL sat_hold: got %h want ff", s_stall_cycles);
        else pass_cnt++;
        tick();
        total++;
        if (s_stall_cycles !== 8'hFF) $display("FAIL sat_no_wrap: got %h want ff", s_stall_cycles);
        else pass_cnt++;
        total++;
        if (stall_cycles !== exp_sc) $display("FAIL wide_count: got %0d want %0d", stall_cycles, exp_sc);
        else pass_cnt++;
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        total++;
        if ({s_stall_cycles, stall_cycles} !== {8'h00, 16'h0000})
            $display("FAIL clear_priority: narrow=%h wide=%h want 0 0", s_stall_cycles, stall_cycles);
        else pass_cnt++;
        tick();
        total++;
        if ({s_stall_cycles, stall_cycles} !== {8'h01, 16'h0001})
            $display("FAIL after_clear: narrow=%h wide=%h want 1 1", s_stall_cycles, stall_cycles);
        else pass_cnt++;
        stall = 6'b000000;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_invalid_capture();
        test_bubble();
        test_hold();
        test_flush();
        test_saturation_clear();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
